axi_bresp_gen: RTL
==================

# axi_bresp_gen

AXI3/AXI4 slave-side write-response generator: the responder that produces the B-channel traffic a response monitor on the master side consumes. It accepts write addresses (AW), tracks write-data bursts (W) in order, and issues one write response (B) per burst with the correct ID and OKAY/SLVERR/DECERR code under valid/ready handshakes. It sits in the slave-side AXI interface logic, beside the register or memory backend that supplies per-beat error indications.

## Interface

Parameters:
- ID_W, 4, width of awid/bid.
- DEPTH, 4, maximum number of outstanding bursts (AW accepted, B not yet accepted); power of 2, ≥2.
- ADDR_LO, 32'h0000_0000, lowest decoded address (inclusive).
- ADDR_HI, 32'h0000_FFFF, highest decoded address (inclusive).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- awvalid  in  1  AW valid.
- awready  out  1  AW ready.
- awid  in  ID_W  AW transaction ID.
- awaddr  in  32  AW start address; decoded against ADDR_LO..ADDR_HI.
- wvalid  in  1  W valid.
- wready  out  1  W ready.
- wlast  in  1  last beat of burst.
- werr  in  1  backend slave error for the current W beat; sampled on W handshake.
- bvalid  out  1  B valid.
- bready  in  1  B ready.
- bid  out  ID_W  B response ID.
- bresp  out  2  B response code: 00 OKAY, 10 SLVERR, 11 DECERR. 01 EXOKAY is never generated.

## Operation

- Storage: DEPTH-entry circular buffer; entry = {id, dec, resp[1:0]}. Three pointers, each log2(DEPTH)+1 bits with wrap bit: wp (AW push), dp (data completion), rp (B pop).
- AW handshake (awvalid & awready): entry[wp] ← {awid, dec = (awaddr < ADDR_LO) | (awaddr > ADDR_HI)}; wp+1.
- awready = (wp − rp) < DEPTH. Full means no AW is accepted.
- wready = (wp ≠ dp): W beats are accepted only for a burst whose AW has already been accepted. Bursts complete in AW order.
- Error tracking: a sticky flag is set on any W handshake with werr=1.
- On a W handshake with wlast=1:
  - entry[dp].resp ← 11 if dec; else 10 if (sticky | werr); else 00.
  - dp+1; sticky cleared in the same cycle.
- bvalid = (dp ≠ rp). While bvalid: bid = entry[rp].id and bresp = entry[rp].resp. Both are 0 when bvalid=0.
- B handshake (bvalid & bready): rp+1.
- AW push, W completion and B pop may all occur in the same cycle. Each pointer updates independently; occupancy stays consistent.
- Once raised, bvalid is held with bid/bresp stable until bready. Responses are never dropped or reordered.
- DECERR bursts still consume all their W beats (wready asserted) before the response is issued.

## Timing

- Reset values: awready=1, wready=0, bvalid=0, bid=0, bresp=00; all pointers and sticky = 0.
- Reset mid-operation discards all outstanding entries with no B issued. Outputs take reset values the cycle after rst is sampled high.
- AW accepted in cycle N → wready=1 in N+1 (when no older burst is pending).
- wlast handshake in cycle N → bvalid=1 in N+1 with the final bid/bresp.
- B handshake in cycle N → next entry presented in N+1 if already complete, otherwise bvalid=0.
- Full (wp − rp = DEPTH): awready=0 starting the cycle after the filling push. A B pop in cycle N raises awready in N+1. An AW is never accepted in the same cycle as a pop while full.
- Pointer arithmetic is modulo 2·DEPTH. Full/empty is determined by pointer difference; the wrap bit is required.
- awready, wready and bvalid are pure functions of registers, with no combinational path from inputs.

## Test plan

- Reset: hold rst 2 cycles → awready=1, wready=0, bvalid=0, bid=0, bresp=00. No B ever issued before an AW.
- Single OKAY burst: AW id=3, addr=0x100, then 4 W beats with werr=0, bready=1 → exactly one B, bid=3, bresp=00, bvalid high 1 cycle after wlast.
- Errors: addr=0x1_0000 with werr=1 on one beat → bresp=11. Next burst id=5 in range with werr on beat 2 of 4 → bresp=10. Following burst id=6, clean → bresp=00 (sticky cleared).
- Backpressure/full: bready=0; issue 4 single-beat bursts ids 1..4 → awready=0 after the 4th AW; a 5th AW waits. bvalid held with bid=1 stable. Then bready=1 → B ids 1,2,3,4,5 in order, one per cycle where data is complete.
- Simultaneous events: at steady state, same-cycle AW push, wlast completion and B pop over 20 single-beat bursts, with the pointer wrap crossed at least twice → no lost or duplicated responses; IDs match AW order.
- Reset mid-operation: 2 bursts outstanding, one with bvalid high → assert rst → bvalid=0, awready=1 next cycle. A fresh burst id=7 afterwards → single B with bid=7, bresp=00.

Source files
------------

// File: rtl/axi_bresp_gen.sv
// AXI write-response generator: tracks accepted AW bursts in a circular buffer,
// folds per-beat backend errors and address decode into one B response per burst.
module axi_bresp_gen #(
  parameter int          ID_W    = 4,
  parameter int          DEPTH   = 4,
  parameter logic [31:0] ADDR_LO = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI = 32'h0000_FFFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic            wvalid,
  output logic            wready,
  input  logic            wlast,
  input  logic            werr,
  output logic            bvalid,
  input  logic            bready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] ONE      = (PW+1)'(1);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PW:0] wp_reg, wp_next;
  logic [PW:0] dp_reg, dp_next;
  logic [PW:0] rp_reg, rp_next;
  logic        sticky_reg, sticky_next;

  logic [ID_W-1:0] id_mem   [DEPTH];
  logic            dec_mem  [DEPTH];
  logic [1:0]      resp_mem [DEPTH];

  logic [PW-1:0] wp_idx, dp_idx, rp_idx;
  logic [PW:0]   used;
  logic          aw_hs, w_hs, w_done, b_hs;
  logic          below_lo, above_hi, addr_dec;
  logic [1:0]    done_resp;

  assign wp_idx = wp_reg[PW-1:0];
  assign dp_idx = dp_reg[PW-1:0];
  assign rp_idx = rp_reg[PW-1:0];
  assign used   = wp_reg - rp_reg;

  // Handshake qualifiers depend only on registered state.
  assign awready = (used != FULL_CNT);
  assign wready  = (wp_reg != dp_reg);
  assign bvalid  = (dp_reg != rp_reg);

  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign w_done = w_hs & wlast;
  assign b_hs   = bvalid & bready;

  // Bounds at the extremes of the address space can never be violated.
  generate
    if (ADDR_LO == 32'h0000_0000) begin : g_lo_open
      assign below_lo = 1'b0;
    end else begin : g_lo_cmp
      assign below_lo = (awaddr < ADDR_LO);
    end
    if (ADDR_HI == 32'hFFFF_FFFF) begin : g_hi_open
      assign above_hi = 1'b0;
    end else begin : g_hi_cmp
      assign above_hi = (awaddr > ADDR_HI);
    end
  endgenerate

  assign addr_dec = below_lo | above_hi;

  always_comb begin
    done_resp = RESP_OKAY;
    if (dec_mem[dp_idx]) begin
      done_resp = RESP_DECERR;
    end else if (sticky_reg | werr) begin
      done_resp = RESP_SLVERR;
    end
  end

  always_comb begin
    wp_next     = wp_reg;
    dp_next     = dp_reg;
    rp_next     = rp_reg;
    sticky_next = sticky_reg;
    if (aw_hs) begin
      wp_next = wp_reg + ONE;
    end
    if (w_hs) begin
      sticky_next = sticky_reg | werr;
    end
    if (w_done) begin
      dp_next     = dp_reg + ONE;
      sticky_next = 1'b0;
    end
    if (b_hs) begin
      rp_next = rp_reg + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_reg     <= '0;
      dp_reg     <= '0;
      rp_reg     <= '0;
      sticky_reg <= 1'b0;
    end else begin
      wp_reg     <= wp_next;
      dp_reg     <= dp_next;
      rp_reg     <= rp_next;
      sticky_reg <= sticky_next;
    end
  end

  // Entry payload needs no reset: validity is implied by the pointers.
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      id_mem[wp_idx]  <= awid;
      dec_mem[wp_idx] <= addr_dec;
    end
    if (w_done) begin
      resp_mem[dp_idx] <= done_resp;
    end
  end

  assign bid   = bvalid ? id_mem[rp_idx]   : '0;
  assign bresp = bvalid ? resp_mem[rp_idx] : 2'b00;

endmodule
